// File: rtl/flash_reader_pkg.sv
// Shared definitions for the SPI flash read engine: FSM states, the standard
// read opcode and the flash address width.
package flash_reader_pkg;

    localparam int unsigned ADDR_W   = 24;
    localparam logic [7:0]  READ_CMD = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_STALL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/flash_reader.sv
// SPI (mode 0) flash sequential reader: sends opcode + 24-bit address, then
// streams bytes out over a valid/ready handshake, pausing the SPI clock when
// the consumer falls behind so no bit is ever lost.
module flash_reader
    import flash_reader_pkg::*;
#(
    parameter int unsigned CountBitWidth = 24,
    parameter logic [7:0]  ReadCommand   = READ_CMD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_address,
    input  logic [CountBitWidth-1:0] byte_count,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     flash_clk,
    output logic                     flash_cs,
    output logic                     flash_mosi,
    input  logic                     flash_miso
);

    localparam logic [4:0]               CMD_LAST  = 5'd7;
    localparam logic [4:0]               ADDR_LAST = 5'(ADDR_W - 1);
    localparam logic [4:0]               BYTE_LAST = 5'd7;
    localparam logic [CountBitWidth-1:0] CNT_ONE   = {{(CountBitWidth-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic                     cs_q, cs_d;
    logic                     sclk_q, sclk_d;
    logic                     mosi_q, mosi_d;
    logic [30:0]              hdr_q, hdr_d;     // header bits still to be sent after the current one
    logic [4:0]               bit_q, bit_d;     // bit index within the current phase / byte
    logic [CountBitWidth-1:0] cnt_q, cnt_d;     // bytes still to be loaded into data_out
    logic [6:0]               rx_q, rx_d;       // first seven bits of the byte being received
    logic [7:0]               dout_q, dout_d;
    logic                     dv_q, dv_d;
    logic                     done_q, done_d;

    // State and datapath registers; reset returns everything to an idle, deselected bus
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            hdr_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            hdr_q   <= hdr_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; sclk_q tells which half of the SPI bit we are in
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        hdr_d   = hdr_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        dv_d    = dv_q & ~data_ready;   // a completed handshake frees the output register
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (byte_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CMD;
                        cs_d    = 1'b0;
                        sclk_d  = 1'b0;
                        mosi_d  = ReadCommand[7];
                        hdr_d   = {ReadCommand[6:0], start_address};
                        cnt_d   = byte_count;
                        bit_d   = '0;
                    end
                end
            end

            ST_CMD, ST_ADDR: begin
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // Falling SPI edge: the only place the MOSI line may change
                    sclk_d = 1'b0;
                    if (state_q == ST_ADDR && bit_q == ADDR_LAST) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                        mosi_d  = 1'b0;
                    end else begin
                        mosi_d = hdr_q[30];
                        hdr_d  = {hdr_q[29:0], 1'b0};
                        if (state_q == ST_CMD && bit_q == CMD_LAST) begin
                            state_d = ST_ADDR;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (cnt_q == '0) begin
                    // Every byte is loaded: release the flash, wait for the last handshake
                    cs_d   = 1'b1;
                    sclk_d = 1'b0;
                    if (!dv_q || data_ready) begin
                        state_d = ST_DONE;
                    end
                end else if (sclk_q) begin
                    sclk_d = 1'b0;
                end else if (bit_q == BYTE_LAST) begin
                    if (dv_q && !data_ready) begin
                        // Hold the final rising edge until the output register is free
                        state_d = ST_STALL;
                    end else begin
                        sclk_d = 1'b1;
                        dout_d = {rx_q, flash_miso};
                        dv_d   = 1'b1;
                        cnt_d  = cnt_q - CNT_ONE;
                        rx_d   = '0;
                        bit_d  = '0;
                    end
                end else begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[5:0], flash_miso};
                    bit_d  = bit_q + 5'd1;
                end
            end

            ST_STALL: begin
                if (data_ready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign flash_clk  = sclk_q;
    assign flash_cs   = cs_q;
    assign flash_mosi = mosi_q;

endmodule

// File: doc/flash_reader.md
FLASH_READER -- requirements
Module: flash_reader

Interface
REQ-001 Parameter: CountBitWidth, default 24, width of byte_count.
REQ-002 Parameter: ReadCommand, default 8'h03, SPI read opcode sent first.
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: start  input  1  request pulse; sampled only in Idle.
REQ-006 Port: start_address  input  24  flash byte address, captured on accepted start.
REQ-007 Port: byte_count  input  CountBitWidth  number of bytes to read, captured on accepted start.
REQ-008 Port: busy  output  1  high from the cycle after an accepted start until the cycle before done.
REQ-009 Port: done  output  1  one-cycle pulse when a transfer completes.
REQ-010 Port: data_out  output  8  received byte.
REQ-011 Port: data_valid  output  1  data_out holds a byte.
REQ-012 Port: data_ready  input  1  consumer accepts data_out when data_valid and data_ready are both high.
REQ-013 Port: flash_clk  output  1  SPI clock, idles low (mode 0).
REQ-014 Port: flash_cs  output  1  chip select, active low.
REQ-015 Port: flash_mosi  output  1  serial command/address out.
REQ-016 Port: flash_miso  input  1  serial data in.

Function
REQ-017 The block SHALL implement states Idle, Command, Address, Data, Stall and Done, with the state enum taken from the package.
REQ-018 In Idle, a start with byte_count=0 SHALL go to Done without asserting flash_cs; otherwise it SHALL go to Command, drive flash_cs=0, flash_clk=0 and flash_mosi=ReadCommand[7] on the next cycle.
REQ-019 Each SPI bit SHALL take 2 clk cycles: flash_clk low for one cycle, then high for one cycle.
REQ-020 flash_mosi SHALL change only on cycles where flash_clk goes high->low.
REQ-021 flash_miso SHALL be sampled on cycles where flash_clk goes low->high.
REQ-022 Command SHALL shift 8 opcode bits MSB-first, then go to Address.
REQ-023 Address SHALL shift 24 address bits MSB-first, then go to Data; the total cmd+addr phase is 64 clk cycles.
REQ-024 flash_mosi SHALL be held 0 in Data and Stall.
REQ-025 In Data, 8 sampled bits SHALL be assembled MSB-first.
REQ-026 After the 8th sample, data_out SHALL be loaded and data_valid SHALL assert on the next cycle.
REQ-027 data_valid SHALL stay high and data_out stable until the handshake.
REQ-028 If the next byte completes while the previous byte is still unaccepted, the FSM SHALL enter Stall: flash_clk held low, flash_cs held low, no bit lost.
REQ-029 Stall SHALL resume Data on the cycle after the handshake.
REQ-030 A byte counter SHALL decrement on each byte loaded into data_out.
REQ-031 When the counter reaches 0, flash_cs SHALL deassert (high) and the FSM SHALL go to Done once the last byte is accepted; no extra SPI clocks SHALL be issued.
REQ-032 Done SHALL pulse done for one cycle and return to Idle.
REQ-033 start in any state other than Idle SHALL be ignored.
REQ-034 Address arithmetic SHALL NOT be performed; the flash auto-increments, and reads crossing 24'hFFFFFF wrap in the flash.
REQ-035 A simultaneous data_valid/data_ready handshake and byte completion SHALL load the new byte with no Stall.

Reset
REQ-036 On rst, state SHALL be Idle, flash_cs=1, flash_clk=0, flash_mosi=0, busy=0, done=0, data_valid=0, data_out=0, and all counters and shift registers SHALL be 0.
REQ-037 rst mid-transfer SHALL take effect on the next clock edge, dropping the in-flight byte.
REQ-038 Reset SHALL take priority over start asserted in the same cycle.

Structure
REQ-039 A shared package flash_reader_pkg SHALL hold the state enum, the read opcode constant and the address width (24).
REQ-040 The block SHALL be a single module with no sub-module; the shift registers are small enough to stay inline.

Verification
REQ-041 Bench: SPI flash model loaded with data[i]=i&8'hFF, data_ready=1, start_address=0, byte_count=4 -> bytes 00,01,02,03 on data_out, flash_cs low for 64+4*16 cycles, then one done pulse.
REQ-042 Bench: start_address=24'h000010, byte_count=2 -> mosi stream 03 00 00 10; data_out 10 then 11.
REQ-043 Bench: byte_count=3, data_ready low for 40 cycles after the first data_valid -> flash_clk frozen low during Stall; bytes 00,01,02 received intact and in order.
REQ-044 Bench: byte_count=0 -> done pulses 2 cycles after start; flash_cs never low.
REQ-045 Bench: rst asserted at cycle 30 of the Address phase -> next cycle flash_cs=1 and busy=0; a new start (addr 5, count 1) returns byte 05.
REQ-046 Bench: start pulsed while busy -> ignored; the transfer completes with the original count.
